// File: rtl/echo_mix_pkg.sv
// Shared definitions for the echo output mixer: FSM encodings, saturation
// limits and the default output FIFO depth.
package echo_mix_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_FADE  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_IDLE  = 2'd3
  } state_e;

  localparam int SAT_MAX        = 32767;
  localparam int SAT_MIN        = -32768;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with count-based full/empty; head reads as zero when
// empty. A push into a full FIFO is accepted only if a pop happens that cycle.
module sample_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/echo_mix.sv
// Dry/echo mixer: attenuated echo added to each dry sample, faded on song end,
// saturated to 16 bits and queued for the codec.
module echo_mix
  import echo_mix_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int GAIN_SHIFT = 1,
  parameter int FADE_LEN   = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] dry_sample,
  input  logic               dry_ready,
  input  logic signed [15:0] echo_sample,
  input  logic               echo_ready,
  input  logic               echo_enable,
  input  logic               song_done,
  input  logic               codec_ready,
  output logic signed [15:0] out_sample,
  output logic               out_valid,
  output logic               overflow,
  output logic               fading
);

  localparam int CW = (FADE_LEN > 1) ? $clog2(FADE_LEN) : 1;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > SAT_MAX)      return 16'(SAT_MAX);
    else if (v < SAT_MIN) return 16'(SAT_MIN);
    else                  return v[15:0];
  endfunction

  state_e             state_q, state_d;
  logic [3:0]         fade_shift_q, fade_shift_d;
  logic [CW-1:0]      fade_cnt_q, fade_cnt_d;
  logic signed [15:0] echo_hold_q;
  logic               echo_fresh_q, echo_fresh_d;
  logic               overflow_q, overflow_d;

  logic               fire_p0;
  logic signed [15:0] echo_term_p0, echo_att_p0;
  logic signed [16:0] sum_p0;
  logic [3:0]         shift_p0;

  logic               vld_p1_q;
  logic signed [16:0] sum_p1_q;
  logic [3:0]         shift_p1_q;
  logic signed [16:0] scaled_p1;
  logic signed [15:0] mix_p1;

  logic [15:0]        fifo_head;
  logic               fifo_empty, fifo_full, pop;

  // Stage 0: pair dry with the latched echo (consumed once) and sum.
  always_comb begin
    fire_p0      = dry_ready && (state_q != ST_DRAIN);
    echo_term_p0 = (echo_fresh_q && echo_enable) ? echo_hold_q : '0;
    echo_att_p0  = echo_term_p0 >>> GAIN_SHIFT;
    sum_p0       = {dry_sample[15], dry_sample} + {echo_att_p0[15], echo_att_p0};
    shift_p0     = (state_q == ST_IDLE) ? 4'd0 : fade_shift_q;
    echo_fresh_d = echo_ready ? 1'b1 : (fire_p0 ? 1'b0 : echo_fresh_q);
  end

  always_comb begin
    state_d      = state_q;
    fade_shift_d = fade_shift_q;
    fade_cnt_d   = fade_cnt_q;
    case (state_q)
      ST_PLAY: begin
        if (song_done) begin
          state_d      = ST_FADE;
          fade_shift_d = 4'd0;
          fade_cnt_d   = '0;
        end
      end
      ST_FADE: begin
        if (fire_p0) begin
          if (fade_cnt_q == CW'(FADE_LEN - 1)) begin
            fade_cnt_d   = '0;
            fade_shift_d = fade_shift_q + 4'd1;
            if (fade_shift_q == 4'd14) state_d = ST_DRAIN;
          end else begin
            fade_cnt_d = fade_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !vld_p1_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (dry_ready) begin
          state_d      = ST_PLAY;
          fade_shift_d = 4'd0;
          fade_cnt_d   = '0;
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_PLAY;
      fade_shift_q <= 4'd0;
      fade_cnt_q   <= '0;
      echo_fresh_q <= 1'b0;
      vld_p1_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fade_shift_q <= fade_shift_d;
      fade_cnt_q   <= fade_cnt_d;
      echo_fresh_q <= echo_fresh_d;
      vld_p1_q     <= fire_p0;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (echo_ready) echo_hold_q <= echo_sample;
    if (fire_p0) begin
      sum_p1_q   <= sum_p0;
      shift_p1_q <= shift_p0;
    end
  end

  // Stage 1: fade scaling and saturation feeding the output FIFO.
  always_comb begin
    scaled_p1  = sum_p1_q >>> shift_p1_q;
    mix_p1     = sat16(scaled_p1);
    pop        = !fifo_empty && codec_ready;
    overflow_d = overflow_q | (vld_p1_q && fifo_full && !pop);
  end

  sample_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (16)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1_q),
    .push_data (mix_p1),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_sample = fifo_head;
  assign out_valid  = !fifo_empty;
  assign overflow   = overflow_q;
  assign fading     = (state_q == ST_FADE) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_echo_mix.sv
// Directed bench for echo_mix: mixing, saturation, echo reuse rules, FIFO
// overflow, fade sequence and asynchronous reset.
module tb_echo_mix;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] dry_sample = '0;
  logic               dry_ready = 1'b0;
  logic signed [15:0] echo_sample = '0;
  logic               echo_ready = 1'b0;
  logic               echo_enable = 1'b1;
  logic               song_done = 1'b0;
  logic               codec_ready = 1'b0;
  logic signed [15:0] out_sample;
  logic               out_valid;
  logic               overflow;
  logic               fading;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  echo_mix #(
    .FIFO_DEPTH (4),
    .GAIN_SHIFT (1),
    .FADE_LEN   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dry_sample  (dry_sample),
    .dry_ready   (dry_ready),
    .echo_sample (echo_sample),
    .echo_ready  (echo_ready),
    .echo_enable (echo_enable),
    .song_done   (song_done),
    .codec_ready (codec_ready),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .overflow    (overflow),
    .fading      (fading)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    dry_ready   = 1'b0;
    echo_ready  = 1'b0;
    song_done   = 1'b0;
    codec_ready = 1'b0;
    echo_enable = 1'b1;
    reset       = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic drive_dry(input logic signed [15:0] d);
    dry_sample = d;
    dry_ready  = 1'b1;
    tick();
    dry_ready  = 1'b0;
  endtask

  task automatic drive_echo(input logic signed [15:0] e);
    echo_sample = e;
    echo_ready  = 1'b1;
    tick();
    echo_ready  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    total++; if (out_sample !== 16'sd0) begin bad++; $display("FAIL reset_sample: got %0d want 0", out_sample); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    total++; if (fading !== 1'b0) begin bad++; $display("FAIL reset_fading: got %0b want 0", fading); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mix_echo();
    codec_ready = 1'b1;
    drive_echo(16'sd400);
    dry_sample = 16'sd1000;
    dry_ready  = 1'b1;
    tick();
    dry_ready  = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mix_latency_early: valid got %0b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mix_latency: valid got %0b want 1", out_valid); end
    total++; if (out_sample !== 16'sd1200) begin bad++; $display("FAIL mix_echo: got %0d want 1200", out_sample); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mix_pop: valid got %0b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    codec_ready = 1'b1;
    drive_echo(16'sd20000);
    drive_dry(16'sd32000);
    tick();
    total++; if (out_sample !== 16'sd32767) begin bad++; $display("FAIL sat_pos: got %0d want 32767", out_sample); end
    tick();
    drive_echo(-16'sd32768);
    drive_dry(-16'sd32768);
    tick();
    total++; if (out_sample !== -16'sd32768) begin bad++; $display("FAIL sat_neg: got %0d want -32768", out_sample); end
    tick();
  endtask

  task automatic test_stale_echo();
    codec_ready = 1'b1;
    drive_dry(16'sd500);
    tick();
    total++; if (out_sample !== 16'sd500) begin bad++; $display("FAIL stale_echo: got %0d want 500", out_sample); end
    tick();
    echo_enable = 1'b0;
    drive_echo(16'sd600);
    drive_dry(16'sd500);
    tick();
    total++; if (out_sample !== 16'sd500) begin bad++; $display("FAIL echo_disable: got %0d want 500", out_sample); end
    tick();
    echo_enable = 1'b1;
  endtask

  task automatic test_echo_collision();
    apply_reset();
    codec_ready = 1'b1;
    drive_echo(16'sd200);
    dry_sample  = 16'sd1000;
    dry_ready   = 1'b1;
    echo_sample = 16'sd800;
    echo_ready  = 1'b1;
    tick();
    dry_ready  = 1'b0;
    echo_ready = 1'b0;
    tick();
    total++; if (out_sample !== 16'sd1100) begin bad++; $display("FAIL collision_old: got %0d want 1100", out_sample); end
    tick();
    drive_dry(16'sd1000);
    tick();
    total++; if (out_sample !== 16'sd1400) begin bad++; $display("FAIL collision_new: got %0d want 1400", out_sample); end
    tick();
    drive_dry(16'sd1000);
    tick();
    total++; if (out_sample !== 16'sd1000) begin bad++; $display("FAIL no_reuse: got %0d want 1000", out_sample); end
    tick();
  endtask

  task automatic test_back_to_back();
    codec_ready = 1'b1;
    dry_sample = 16'sd10; dry_ready = 1'b1;
    tick();
    dry_sample = 16'sd20;
    tick();
    total++; if (out_sample !== 16'sd10) begin bad++; $display("FAIL b2b_0: got %0d want 10", out_sample); end
    dry_sample = 16'sd30;
    tick();
    dry_ready = 1'b0;
    total++; if (out_sample !== 16'sd20) begin bad++; $display("FAIL b2b_1: got %0d want 20", out_sample); end
    tick();
    total++; if (out_sample !== 16'sd30) begin bad++; $display("FAIL b2b_2: got %0d want 30", out_sample); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: valid got %0b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    apply_reset();
    codec_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      dry_sample = 16'(i);
      dry_ready  = 1'b1;
      tick();
    end
    dry_ready = 1'b0;
    tick();
    tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0b want 1", overflow); end
    codec_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (out_sample !== 16'(i)) begin bad++; $display("FAIL ovf_entry%0d: got %0d want %0d", i, out_sample, i); end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_held4: valid got %0b want 0", out_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    codec_ready = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      dry_sample = 16'(i);
      dry_ready  = 1'b1;
      tick();
    end
    dry_ready = 1'b0;
    tick();
    tick();
    drive_dry(16'sd15);
    codec_ready = 1'b1;
    tick();
    codec_ready = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf: got %0b want 0", overflow); end
    codec_ready = 1'b1;
    for (int i = 12; i <= 15; i++) begin
      total++; if (out_sample !== 16'(i)) begin bad++; $display("FAIL fullpop_entry%0d: got %0d want %0d", i, out_sample, i); end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty: valid got %0b want 0", out_valid); end
  endtask

  task automatic test_fade();
    int exp_v;
    apply_reset();
    codec_ready = 1'b1;
    total++; if (fading !== 1'b0) begin bad++; $display("FAIL fade_pre: got %0b want 0", fading); end
    song_done = 1'b1;
    tick();
    song_done = 1'b0;
    total++; if (fading !== 1'b1) begin bad++; $display("FAIL fade_start: got %0b want 1", fading); end
    for (int k = 0; k < 30; k++) begin
      exp_v = 16384 >> (k / 2);
      drive_dry(16'sd16384);
      tick();
      total++; if (out_sample !== 16'(exp_v)) begin bad++; $display("FAIL fade_step%0d: got %0d want %0d", k, out_sample, exp_v); end
      tick();
    end
    total++; if (fading !== 1'b1) begin bad++; $display("FAIL fade_drain: got %0b want 1", fading); end
    drive_dry(16'sd16384);
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_ignore: valid got %0b want 0", out_valid); end
    total++; if (fading !== 1'b0) begin bad++; $display("FAIL fade_idle: got %0b want 0", fading); end
    drive_dry(16'sd100);
    tick();
    total++; if (out_sample !== 16'sd100) begin bad++; $display("FAIL idle_restart: got %0d want 100", out_sample); end
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    codec_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      dry_sample = 16'(i * 7);
      dry_ready  = 1'b1;
      tick();
    end
    dry_ready = 1'b0;
    tick();
    tick();
    codec_ready = 1'b1;
    tick();
    codec_ready = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_valid: got %0b want 1", out_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL areset_pre_ovf: got %0b want 1", overflow); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %0b want 0", out_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL areset_ovf: got %0b want 0", overflow); end
    total++; if (out_sample !== 16'sd0) begin bad++; $display("FAIL areset_sample: got %0d want 0", out_sample); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_mix_echo();
    test_saturation();
    test_stale_echo();
    test_echo_collision();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_fade();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
